wb_regfile: RTL and testbench

//  Writeback-stage consumer of the MEM/WB pipeline register plus the architectural register file.
//  - Selects the writeback data and commits it to a 2^REGFILE_ADDRESS_WIDTH x DATA_WIDTH register array.
//  - Serves two decode read ports with same-cycle WB bypass and a registered forwarding tap for EX.
//  - Provides a host debug read/write port with a req/ack handshake, and counts retired instructions.

---
 rtl/wb_regfile_if.sv | 22 ++
 rtl/wb_regfile.sv | 154 +++++++++++++++
 tb/tb_wb_regfile.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Host debug port bundle for wb_regfile: request/ack handshake with read/write data.
interface wb_regfile_if #(
  parameter int DATA_WIDTH            = 64,
  parameter int REGFILE_ADDRESS_WIDTH = 5
);
  logic                             host_req;
  logic                             host_we;
  logic [REGFILE_ADDRESS_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0]            host_wdata;
  logic [DATA_WIDTH-1:0]            host_rdata;
  logic                             host_ack;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage + architectural register file.
// WB commits have priority over the host debug port for the single write port;
// host writes stall while WB commits, host reads complete without stalling.
module wb_regfile #(
  parameter int DATA_WIDTH            = 64,
  parameter int REGFILE_ADDRESS_WIDTH = 5,
  parameter int RETIRE_CNT_WIDTH      = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wb_valid,
  input  logic                             reg_write_in,
  input  logic                             mem_to_reg_in,
  input  logic [DATA_WIDTH-1:0]            mem_read_data_in,
  input  logic [DATA_WIDTH-1:0]            reg_data_in,
  input  logic [REGFILE_ADDRESS_WIDTH-1:0] rd_in,
  input  logic [REGFILE_ADDRESS_WIDTH-1:0] rs1_addr,
  input  logic [REGFILE_ADDRESS_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0]            rs1_data,
  output logic [DATA_WIDTH-1:0]            rs2_data,
  output logic                             wb_fwd_valid,
  output logic [REGFILE_ADDRESS_WIDTH-1:0] wb_fwd_rd,
  output logic [DATA_WIDTH-1:0]            wb_fwd_data,
  output logic [RETIRE_CNT_WIDTH-1:0]      retire_count,
  wb_regfile_if.slave                      host
);

  localparam int NREG = 1 << REGFILE_ADDRESS_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} state_t;

  state_t                           state_q, state_d;
  logic [DATA_WIDTH-1:0]            regs_q [NREG];
  logic [DATA_WIDTH-1:0]            regs_d [NREG];
  logic                             lat_we_q, lat_we_d;
  logic [REGFILE_ADDRESS_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0]            lat_wdata_q, lat_wdata_d;
  logic [DATA_WIDTH-1:0]            rdata_q, rdata_d;
  logic                             fwd_valid_q, fwd_valid_d;
  logic [REGFILE_ADDRESS_WIDTH-1:0] fwd_rd_q, fwd_rd_d;
  logic [DATA_WIDTH-1:0]            fwd_data_q, fwd_data_d;
  logic [RETIRE_CNT_WIDTH-1:0]      retire_q, retire_d;

  logic                             commit;
  logic [DATA_WIDTH-1:0]            wb_data;
  logic [DATA_WIDTH-1:0]            host_read_val;
  logic                             host_wr_en;
  logic                             host_rd_ld;

  // Writeback data select and commit qualification (x0 is never written).
  always_comb begin
    wb_data = mem_to_reg_in ? mem_read_data_in : reg_data_in;
    commit  = wb_valid & reg_write_in & (rd_in != '0);
  end

  // Decode and host read ports: x0 reads zero, same-cycle commit bypasses the array.
  always_comb begin
    rs1_data      = '0;
    rs2_data      = '0;
    host_read_val = '0;
    if (rs1_addr != '0)
      rs1_data = (commit && (rs1_addr == rd_in)) ? wb_data : regs_q[rs1_addr];
    if (rs2_addr != '0)
      rs2_data = (commit && (rs2_addr == rd_in)) ? wb_data : regs_q[rs2_addr];
    if (lat_addr_q != '0)
      host_read_val = (commit && (lat_addr_q == rd_in)) ? wb_data : regs_q[lat_addr_q];
  end

  // Host FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Host FSM next state: a latched write waits while WB holds the write port.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (host.host_req) state_d = S_PEND;
      S_PEND:  if (!(lat_we_q && commit)) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host FSM outputs: write enable, read capture strobe and completion pulse.
  always_comb begin
    host_wr_en    = (state_q == S_PEND) && lat_we_q && !commit && (lat_addr_q != '0);
    host_rd_ld    = (state_q == S_PEND) && !lat_we_q;
    host.host_ack = (state_q == S_ACK);
  end

  // Request latch (only sampled in IDLE) and read-data capture.
  always_comb begin
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    if ((state_q == S_IDLE) && host.host_req) begin
      lat_we_d    = host.host_we;
      lat_addr_d  = host.host_addr;
      lat_wdata_d = host.host_wdata;
    end
    if (host_rd_ld) rdata_d = host_read_val;
  end

  assign host.host_rdata = rdata_q;

  // Array next value: WB commit first, otherwise a pending host write.
  always_comb begin
    regs_d = regs_q;
    if (commit)          regs_d[rd_in]      = wb_data;
    else if (host_wr_en) regs_d[lat_addr_q] = lat_wdata_q;
  end

  // Forwarding tap and retire counter next values.
  always_comb begin
    fwd_valid_d = commit;
    fwd_rd_d    = rd_in;
    fwd_data_d  = wb_data;
    retire_d    = retire_q + RETIRE_CNT_WIDTH'(wb_valid);
  end

  // All datapath and control state, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q      <= '{default: '0};
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
      retire_q    <= '0;
    end else begin
      regs_q      <= regs_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
      retire_q    <= retire_d;
    end
  end

  assign wb_fwd_valid = fwd_valid_q;
  assign wb_fwd_rd    = fwd_rd_q;
  assign wb_fwd_data  = fwd_data_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid, reg_write_in, mem_to_reg_in;
  logic [63:0] mem_read_data_in, reg_data_in;
  logic [4:0]  rd_in, rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data, wb_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [3:0]  retire_count;

  wb_regfile_if #(.DATA_WIDTH(64), .REGFILE_ADDRESS_WIDTH(5)) hif ();

  wb_regfile #(.DATA_WIDTH(64), .REGFILE_ADDRESS_WIDTH(5), .RETIRE_CNT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_read_data_in(mem_read_data_in),
    .reg_data_in(reg_data_in), .rd_in(rd_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data), .retire_count(retire_count),
    .host(hif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: register contents, host transaction progress, registered outputs.
  logic [63:0] mregs [32];
  bit          m_pend, m_ack, m_lwe;
  logic [4:0]  m_laddr;
  logic [63:0] m_lwdata, m_rdata;
  logic        m_fv;
  logic [4:0]  m_frd;
  logic [63:0] m_fdata;
  logic [3:0]  m_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_commit();
    return wb_valid && reg_write_in && (rd_in != 5'd0);
  endfunction

  function automatic logic [63:0] m_wbd();
    return mem_to_reg_in ? mem_read_data_in : reg_data_in;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (m_commit() && a == rd_in) return m_wbd();
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    m_pend = 0; m_ack = 0; m_lwe = 0; m_laddr = 0; m_lwdata = 0; m_rdata = 0;
    m_fv = 0; m_frd = 0; m_fdata = 0; m_ret = 0;
  endtask

  task automatic drive_idle();
    wb_valid = 0; reg_write_in = 0; mem_to_reg_in = 0;
    mem_read_data_in = 0; reg_data_in = 0; rd_in = 0; rs1_addr = 0; rs2_addr = 0;
    hif.host_req = 0; hif.host_we = 0; hif.host_addr = 0; hif.host_wdata = 0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
  endtask

  // One clock: compare every output against the model, then advance the model at the edge.
  task automatic cycle();
    logic        c;
    logic [63:0] d, rv;
    #1;
    chk("rs1_data", rs1_data, m_read(rs1_addr));
    chk("rs2_data", rs2_data, m_read(rs2_addr));
    chk("wb_fwd_valid", {63'd0, wb_fwd_valid}, {63'd0, m_fv});
    chk("wb_fwd_rd", {59'd0, wb_fwd_rd}, {59'd0, m_frd});
    chk("wb_fwd_data", wb_fwd_data, m_fdata);
    chk("retire_count", {60'd0, retire_count}, {60'd0, m_ret});
    chk("host_ack", {63'd0, hif.host_ack}, {63'd0, m_ack});
    chk("host_rdata", hif.host_rdata, m_rdata);
    @(posedge clk);
    c  = m_commit();
    d  = m_wbd();
    rv = m_read(m_laddr);
    if (m_ack) begin
      m_ack = 0;
    end else if (m_pend) begin
      if (m_lwe) begin
        if (!c) begin
          if (m_laddr != 5'd0) mregs[m_laddr] = m_lwdata;
          m_pend = 0; m_ack = 1;
        end
      end else begin
        m_rdata = rv; m_pend = 0; m_ack = 1;
      end
    end else if (hif.host_req) begin
      m_lwe = hif.host_we; m_laddr = hif.host_addr; m_lwdata = hif.host_wdata; m_pend = 1;
    end
    if (c) mregs[rd_in] = d;
    m_fv = c; m_frd = rd_in; m_fdata = d;
    if (wb_valid) m_ret = m_ret + 4'd1;
    @(negedge clk);
  endtask

  task automatic set_commit(input logic [4:0] rd, input logic [63:0] val);
    wb_valid = 1; reg_write_in = 1; mem_to_reg_in = 0; reg_data_in = val; rd_in = rd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    drive_idle();
    model_reset();

    // Reset state
    rs1_addr = 5'd5;
    @(negedge clk);
    #1;
    chk("reset rs1", rs1_data, 64'd0);
    chk("reset fwd_valid", {63'd0, wb_fwd_valid}, 64'd0);
    chk("reset fwd_data", wb_fwd_data, 64'd0);
    chk("reset retire", {60'd0, retire_count}, 64'd0);
    chk("reset ack", {63'd0, hif.host_ack}, 64'd0);
    chk("reset rdata", hif.host_rdata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Load commit to x3 with same-cycle bypass
    wb_valid = 1; reg_write_in = 1; rd_in = 5'd3; mem_to_reg_in = 1;
    mem_read_data_in = 64'hAAAA; reg_data_in = 64'h5555; rs1_addr = 5'd3;
    #1;
    chk("bypass rs1", rs1_data, 64'hAAAA);
    cycle();
    chk("fwd valid", {63'd0, wb_fwd_valid}, 64'd1);
    chk("fwd rd", {59'd0, wb_fwd_rd}, 64'd3);
    chk("fwd data", wb_fwd_data, 64'hAAAA);
    drive_idle();
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    chk("array r3", rs1_data, 64'hAAAA);
    chk("array r3 port2", rs2_data, 64'hAAAA);
    cycle();

    // Commit to x0 is dropped but still retires
    set_commit(5'd0, 64'hFFFF);
    rs1_addr = 5'd0;
    #1;
    chk("x0 read", rs1_data, 64'd0);
    cycle();
    chk("x0 fwd_valid", {63'd0, wb_fwd_valid}, 64'd0);
    chk("x0 retire", {60'd0, retire_count}, 64'd2);

    // Host write r7 stalled by three consecutive commits
    drive_idle();
    hif.host_req = 1; hif.host_we = 1; hif.host_addr = 5'd7; hif.host_wdata = 64'h1234;
    set_commit(5'd4, 64'h40);
    cycle();
    hif.host_req = 0;
    set_commit(5'd5, 64'h50);
    cycle();
    chk("stall ack 1", {63'd0, hif.host_ack}, 64'd0);
    set_commit(5'd6, 64'h60);
    cycle();
    chk("stall ack 2", {63'd0, hif.host_ack}, 64'd0);
    drive_idle();
    cycle();
    chk("write ack", {63'd0, hif.host_ack}, 64'd1);
    rs2_addr = 5'd7;
    #1;
    chk("host wrote r7", rs2_data, 64'h1234);
    cycle();

    // Host read r9 bypassing a same-cycle commit
    drive_idle();
    hif.host_req = 1; hif.host_we = 0; hif.host_addr = 5'd9;
    cycle();
    hif.host_req = 0;
    set_commit(5'd9, 64'h77);
    cycle();
    chk("read ack", {63'd0, hif.host_ack}, 64'd1);
    chk("read bypass", hif.host_rdata, 64'h77);
    drive_idle();
    cycle();

    // Reset while a host write is pending
    hif.host_req = 1; hif.host_we = 1; hif.host_addr = 5'd10; hif.host_wdata = 64'h55;
    cycle();
    hif.host_req = 0;
    pulse_reset();
    rs1_addr = 5'd10;
    cycle();
    chk("reset pend ack", {63'd0, hif.host_ack}, 64'd0);
    cycle();
    chk("reset pend ack2", {63'd0, hif.host_ack}, 64'd0);
    hif.host_req = 1; hif.host_we = 0; hif.host_addr = 5'd3;
    cycle();
    hif.host_req = 0;
    cycle();
    chk("post reset ack", {63'd0, hif.host_ack}, 64'd1);
    chk("post reset rdata", hif.host_rdata, 64'd0);
    cycle();

    // Retire counter wraps at 4 bits
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      wb_valid = 1; reg_write_in = 0; rd_in = 5'($urandom_range(0, 31));
      cycle();
    end
    chk("retire wrap", {60'd0, retire_count}, 64'd1);
    drive_idle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      wb_valid         = ($urandom_range(0, 3) != 0);
      reg_write_in     = ($urandom_range(0, 3) != 0);
      mem_to_reg_in    = 1'($urandom);
      mem_read_data_in = {$urandom, $urandom};
      reg_data_in      = {$urandom, $urandom};
      rd_in            = 5'($urandom_range(0, 7));
      rs1_addr         = 5'($urandom_range(0, 7));
      rs2_addr         = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 7));
      hif.host_req     = ($urandom_range(0, 2) == 0);
      hif.host_we      = 1'($urandom);
      hif.host_addr    = 5'($urandom_range(0, 7));
      hif.host_wdata   = {$urandom, $urandom};
      if (i == 400) pulse_reset();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
